// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the execute-stage branch resolver.
package branch_resolver_pkg;

  localparam int PC_W_DEF = 12;
  // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 7.
  localparam int FCNT_W   = 3;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_J    = 3'd3,
    BR_JAL  = 3'd4,
    BR_JR   = 3'd5,
    BR_BEX  = 3'd6
  } br_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Execute-stage <-> branch resolver signal bundle.
interface branch_resolver_if
  import branch_resolver_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [2:0]       br_op;
  logic             isNotEqual;
  logic             isLessThan;
  logic             bex_nz;
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  imm_off;
  logic [PC_W-1:0]  abs_target;
  logic             stall;
  logic             ready;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output in_valid, br_op, isNotEqual, isLessThan, bex_nz,
           pc_plus1, imm_off, abs_target, stall,
    input  ready, redirect, redirect_pc, flush, taken_cnt
  );

  modport slave (
    input  in_valid, br_op, isNotEqual, isLessThan, bex_nz,
           pc_plus1, imm_off, abs_target, stall,
    output ready, redirect, redirect_pc, flush, taken_cnt
  );
endinterface

// File: rtl/branch_resolver_cond.sv
// Combinational taken/target-kind decode for one control-transfer op.
module branch_resolver_cond
  import branch_resolver_pkg::*;
(
  input  logic [2:0] br_op_i,
  input  logic       is_not_equal_i,
  input  logic       is_less_than_i,
  input  logic       bex_nz_i,
  output logic       taken_o,
  output logic       use_rel_o
);

  // Decode taken and whether the target is pc_plus1+imm_off (relative) or abs_target.
  always_comb begin
    taken_o   = 1'b0;
    use_rel_o = 1'b0;
    case (br_op_i)
      BR_BNE: begin
        taken_o   = is_not_equal_i;
        use_rel_o = 1'b1;
      end
      BR_BLT: begin
        // A "less than" with equal operands means the flags disagree: not taken.
        taken_o   = is_less_than_i & is_not_equal_i;
        use_rel_o = 1'b1;
      end
      BR_J, BR_JAL, BR_JR: taken_o = 1'b1;
      BR_BEX:              taken_o = bex_nz_i;
      default:             taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage control-transfer resolver: one-cycle redirect, fixed flush
// window, saturating taken counter.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
)(
  input  logic              clock,
  input  logic              reset,
  branch_resolver_if.slave  bus
);

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                redirect_q;
  logic [PC_W-1:0]     redirect_pc_q;
  logic [CNT_W-1:0]    taken_cnt_q;

  logic                taken, use_rel;
  logic                accept, take;
  logic [PC_W-1:0]     target;
  logic                ready, flush;

  branch_resolver_cond u_branch_cond (
    .br_op_i        (bus.br_op),
    .is_not_equal_i (bus.isNotEqual),
    .is_less_than_i (bus.isLessThan),
    .bex_nz_i       (bus.bex_nz),
    .taken_o        (taken),
    .use_rel_o      (use_rel)
  );

  assign accept = bus.in_valid & ready & ~bus.stall;
  assign take   = accept & taken;
  // Relative target wraps modulo 2^PC_W by construction of the adder width.
  assign target = use_rel ? (bus.pc_plus1 + bus.imm_off) : bus.abs_target;

  // FSM state and flush-window counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state: enter FLUSH on a taken accept, count down only when not stalled.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (!bus.stall) begin
          if (fcnt_q == '0) state_d = ST_IDLE;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: flush follows the state, so it drops as soon as reset hits.
  always_comb begin
    ready = (state_q == ST_IDLE);
    flush = (state_q == ST_FLUSH);
  end

  // Redirect pulse, held target and saturating taken count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      taken_cnt_q   <= '0;
    end else begin
      // Takes can only happen from IDLE, so the pulse never repeats.
      redirect_q <= take;
      if (take) begin
        redirect_pc_q <= target;
        if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 1'b1;
      end
    end
  end

  assign bus.ready       = ready;
  assign bus.flush       = flush;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: stimulus pushes expected redirects,
// monitors pop and compare whenever a redirect pulse appears.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if #(.PC_W(12), .CNT_W(16)) bus ();
  branch_resolver_if #(.PC_W(12), .CNT_W(3))  bus2 ();

  branch_resolver #(.PC_W(12), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Small counter and single-cycle flush so saturation is reachable quickly.
  branch_resolver #(.PC_W(12), .FLUSH_CYCLES(1), .CNT_W(3)) dut2 (
    .clock (clk),
    .reset (rst),
    .bus   (bus2)
  );

  assign bus2.br_op      = bus.br_op;
  assign bus2.isNotEqual = bus.isNotEqual;
  assign bus2.isLessThan = bus.isLessThan;
  assign bus2.bex_nz     = bus.bex_nz;
  assign bus2.pc_plus1   = bus.pc_plus1;
  assign bus2.imm_off    = bus.imm_off;
  assign bus2.abs_target = bus.abs_target;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q1[$];
  exp_t q2[$];
  logic red1_prev = 1'b0;
  logic red2_prev = 1'b0;
  logic [15:0] sat_exp [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the main instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && bus.redirect === 1'b1) begin
      check("dut1_redirect_single_cycle", {31'd0, red1_prev}, 32'd0);
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL dut1_unexpected_redirect: pc=0x%0h, no redirect expected", bus.redirect_pc);
      end else begin
        e = q1.pop_front();
        $display("[TB] dut1 redirect pc=0x%03h cnt=%0d (expect pc=0x%03h cnt=%0d)",
                 bus.redirect_pc, bus.taken_cnt, e.pc, e.cnt);
        check("dut1_redirect_pc", {20'd0, bus.redirect_pc}, {20'd0, e.pc});
        check("dut1_taken_cnt",   {16'd0, bus.taken_cnt},   {16'd0, e.cnt});
      end
    end
    red1_prev = bus.redirect & ~rst;
  end

  // Monitor for the saturation instance.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && bus2.redirect === 1'b1) begin
      check("dut2_redirect_single_cycle", {31'd0, red2_prev}, 32'd0);
      if (q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL dut2_unexpected_redirect: pc=0x%0h, no redirect expected", bus2.redirect_pc);
      end else begin
        e = q2.pop_front();
        $display("[TB] dut2 redirect pc=0x%03h cnt=%0d (expect pc=0x%03h cnt=%0d)",
                 bus2.redirect_pc, bus2.taken_cnt, e.pc, e.cnt);
        check("dut2_redirect_pc", {20'd0, bus2.redirect_pc}, {20'd0, e.pc});
        check("dut2_taken_cnt",   {29'd0, bus2.taken_cnt},   {16'd0, e.cnt});
      end
    end
    red2_prev = bus2.redirect & ~rst;
  end

  task automatic drive(input logic [2:0] op, input logic ne, input logic lt, input logic bnz,
                       input logic [11:0] pc1, input logic [11:0] imm, input logic [11:0] abs_t);
    bus.br_op      = op;
    bus.isNotEqual = ne;
    bus.isLessThan = lt;
    bus.bex_nz     = bnz;
    bus.pc_plus1   = pc1;
    bus.imm_off    = imm;
    bus.abs_target = abs_t;
  endtask

  // One-cycle issue on the main instance; expected redirect queued if taken.
  task automatic send(input logic [2:0] op, input logic ne, input logic lt, input logic bnz,
                      input logic [11:0] pc1, input logic [11:0] imm, input logic [11:0] abs_t,
                      input bit exp_taken, input logic [11:0] exp_pc, input logic [15:0] exp_cnt);
    @(negedge clk);
    drive(op, ne, lt, bnz, pc1, imm, abs_t);
    bus.in_valid = 1'b1;
    if (exp_taken) q1.push_back('{exp_pc, exp_cnt});
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Count flush cycles from now, optionally stalling the first few of them.
  task automatic watch_flush(input string name, input int stall_cycles, input int exp_cycles);
    int n = 0;
    int guard = 0;
    while (bus.flush === 1'b1 && guard < 30) begin
      check({name, "_ready_low"}, {31'd0, bus.ready}, 32'd0);
      n++;
      bus.stall = (n <= stall_cycles);
      @(negedge clk);
      guard++;
    end
    bus.stall = 1'b0;
    check({name, "_flush_cycles"}, n, exp_cycles);
    check({name, "_ready_back"}, {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic check_quiet(input string name, input logic [15:0] exp_cnt);
    check({name, "_flush"},    {31'd0, bus.flush},     32'd0);
    check({name, "_ready"},    {31'd0, bus.ready},     32'd1);
    check({name, "_taken_cnt"}, {16'd0, bus.taken_cnt}, {16'd0, exp_cnt});
  endtask

  initial begin
    int n;
    int guard;
    sat_exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd7};
    bus.in_valid  = 1'b0;
    bus.stall     = 1'b0;
    bus2.in_valid = 1'b0;
    bus2.stall    = 1'b0;
    drive(3'd0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",       {31'd0, bus.ready},       32'd1);
    check("rst_redirect",    {31'd0, bus.redirect},    32'd0);
    check("rst_flush",       {31'd0, bus.flush},       32'd0);
    check("rst_redirect_pc", {20'd0, bus.redirect_pc}, 32'd0);
    check("rst_taken_cnt",   {16'd0, bus.taken_cnt},   32'd0);
    check("rst2_ready",      {31'd0, bus2.ready},      32'd1);
    check("rst2_taken_cnt",  {29'd0, bus2.taken_cnt},  32'd0);
    rst = 1'b0;

    // Not-taken cases: none of these may redirect or flush
    send(BR_BNE, 1'b0, 1'b0, 1'b1, 12'h010, 12'h005, 12'h200, 1'b0, 12'h000, 16'd0);
    check_quiet("bne_nt", 16'd0);
    send(BR_BLT, 1'b0, 1'b1, 1'b1, 12'h010, 12'h005, 12'h200, 1'b0, 12'h000, 16'd0);
    check_quiet("blt_flags_disagree", 16'd0);
    send(3'd7,   1'b1, 1'b1, 1'b1, 12'h010, 12'h005, 12'h200, 1'b0, 12'h000, 16'd0);
    check_quiet("op7", 16'd0);
    send(BR_BEX, 1'b1, 1'b1, 1'b0, 12'h010, 12'h005, 12'h200, 1'b0, 12'h000, 16'd0);
    check_quiet("bex_zero", 16'd0);
    send(BR_NONE, 1'b1, 1'b1, 1'b1, 12'h010, 12'h005, 12'h200, 1'b0, 12'h000, 16'd0);
    check_quiet("none", 16'd0);

    // BNE taken: 0x010 + 0x005 = 0x015
    send(BR_BNE, 1'b1, 1'b0, 1'b0, 12'h010, 12'h005, 12'h3FF, 1'b1, 12'h015, 16'd1);
    watch_flush("bne_taken", 0, 2);

    // BLT backward with wrap: 0x002 + 0xFFC = 0xFFE
    send(BR_BLT, 1'b1, 1'b1, 1'b0, 12'h002, 12'hFFC, 12'h3FF, 1'b1, 12'hFFE, 16'd2);
    watch_flush("blt_wrap", 0, 2);

    // BEX taken uses the absolute target
    send(BR_BEX, 1'b0, 1'b0, 1'b1, 12'h100, 12'h001, 12'h7FF, 1'b1, 12'h7FF, 16'd3);
    watch_flush("bex_taken", 0, 2);

    // JR with a 3-cycle stall inside the flush window: 5 flush cycles total
    send(BR_JR, 1'b1, 1'b0, 1'b0, 12'h400, 12'h011, 12'h3A0, 1'b1, 12'h3A0, 16'd4);
    watch_flush("jr_stall", 3, 5);

    // JAL then BNE with in_valid held: BNE only accepted after the window
    @(negedge clk);
    drive(BR_JAL, 1'b0, 1'b0, 1'b0, 12'h500, 12'h000, 12'h123);
    bus.in_valid = 1'b1;
    q1.push_back('{12'h123, 16'd5});
    @(negedge clk);
    drive(BR_BNE, 1'b1, 1'b0, 1'b0, 12'h100, 12'h020, 12'h000);
    q1.push_back('{12'h120, 16'd6});
    n = 0;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 30) begin
      n++;
      @(negedge clk);
      guard++;
    end
    check("b2b_wait_cycles", n, 2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    watch_flush("b2b_bne", 0, 2);

    // Reset in the middle of a flush window acts immediately
    @(negedge clk);
    drive(BR_J, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'h055);
    bus.in_valid = 1'b1;
    q1.push_back('{12'h055, 16'd7});
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rstmid_flush_before", {31'd0, bus.flush}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_flush",       {31'd0, bus.flush},       32'd0);
    check("rstmid_ready",       {31'd0, bus.ready},       32'd1);
    check("rstmid_taken_cnt",   {16'd0, bus.taken_cnt},   32'd0);
    check("rstmid_redirect",    {31'd0, bus.redirect},    32'd0);
    check("rstmid_redirect_pc", {20'd0, bus.redirect_pc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation on the 3-bit counter instance, FLUSH_CYCLES=1
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(BR_J, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 12'(12'h0A0 + i));
      bus2.in_valid = 1'b1;
      q2.push_back('{12'(12'h0A0 + i), sat_exp[i]});
      @(negedge clk);
      bus2.in_valid = 1'b0;
      check("sat_flush_one", {31'd0, bus2.flush}, 32'd1);
      @(negedge clk);
      check("sat_flush_done", {31'd0, bus2.flush}, 32'd0);
      check("sat_ready_back", {31'd0, bus2.ready}, 32'd1);
    end
    check("sat_final_cnt", {29'd0, bus2.taken_cnt}, 32'd7);
    check("dut1_quiet_after", {16'd0, bus.taken_cnt}, 32'd0);

    repeat (3) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
